einstein_keyboard: RTL and testbench



---
 rtl/einstein_kbd_pkg.sv | 37 +++
 rtl/einstein_kbd_map.sv | 64 ++++++
 rtl/einstein_keyboard.sv | 136 +++++++++++++
 tb/tb_einstein_keyboard.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/einstein_kbd_pkg.sv
// Shared types and constants for the Tatung Einstein keyboard adapter.
//   key_kind_t  : what a decoded PS/2 key does (matrix key or a modifier)
//   map_entry_t : decoded key kind plus matrix row/column
//   Sc*         : set-2 scancodes for the keys the adapter singles out
package einstein_kbd_pkg;

    typedef enum logic [2:0] {
        KindNone,
        KindMatrix,
        KindShiftL,
        KindShiftR,
        KindCtrl,
        KindGraph
    } key_kind_t;

    typedef struct packed {
        key_kind_t  kind;
        logic [2:0] row;
        logic [2:0] col;
    } map_entry_t;

    localparam logic [7:0] ScA      = 8'h1C;  // row 1, col 0
    localparam logic [7:0] ScQ      = 8'h15;  // row 0, col 0
    localparam logic [7:0] ScReturn = 8'h5A;  // row 6, col 7
    localparam logic [7:0] ScUp     = 8'h75;  // extended (E0): row 7, col 2
    localparam logic [7:0] ScShiftL = 8'h12;
    localparam logic [7:0] ScShiftR = 8'h59;
    localparam logic [7:0] ScCtrl   = 8'h14;
    localparam logic [7:0] ScGraph  = 8'h11;  // left ALT

    localparam map_entry_t EntryNone = '{kind: KindNone, row: 3'd0, col: 3'd0};

    function automatic map_entry_t mat(input int unsigned r, input int unsigned c);
        return '{kind: KindMatrix, row: 3'(r), col: 3'(c)};
    endfunction

endpackage

// File: rtl/einstein_kbd_map.sv
// Registered lookup from a PS/2 key {ext, code} to its place on the Einstein keyboard.
//   clk_sys : system clock
//   key_i   : {extended (E0) flag, set-2 scancode}
//   entry_o : decoded kind/row/col, one cycle after key_i
module einstein_kbd_map
    import einstein_kbd_pkg::*;
(
    input  logic       clk_sys,
    input  logic [8:0] key_i,
    output map_entry_t entry_o
);

    map_entry_t entry_d;

    // Bit 8 of the case label is the E0 prefix, so 9'h175 (UP) never aliases 9'h075 (KP 8).
    always_comb begin
        entry_d = EntryNone;
        case (key_i)
            9'h015: entry_d = mat(0, 0);  9'h01D: entry_d = mat(0, 1);  // Q W
            9'h024: entry_d = mat(0, 2);  9'h02D: entry_d = mat(0, 3);  // E R
            9'h02C: entry_d = mat(0, 4);  9'h035: entry_d = mat(0, 5);  // T Y
            9'h03C: entry_d = mat(0, 6);  9'h043: entry_d = mat(0, 7);  // U I
            9'h01C: entry_d = mat(1, 0);  9'h01B: entry_d = mat(1, 1);  // A S
            9'h023: entry_d = mat(1, 2);  9'h02B: entry_d = mat(1, 3);  // D F
            9'h034: entry_d = mat(1, 4);  9'h033: entry_d = mat(1, 5);  // G H
            9'h03B: entry_d = mat(1, 6);  9'h042: entry_d = mat(1, 7);  // J K
            9'h01A: entry_d = mat(2, 0);  9'h022: entry_d = mat(2, 1);  // Z X
            9'h021: entry_d = mat(2, 2);  9'h02A: entry_d = mat(2, 3);  // C V
            9'h032: entry_d = mat(2, 4);  9'h031: entry_d = mat(2, 5);  // B N
            9'h03A: entry_d = mat(2, 6);  9'h04B: entry_d = mat(2, 7);  // M L
            9'h016: entry_d = mat(3, 0);  9'h01E: entry_d = mat(3, 1);  // 1 2
            9'h026: entry_d = mat(3, 2);  9'h025: entry_d = mat(3, 3);  // 3 4
            9'h02E: entry_d = mat(3, 4);  9'h036: entry_d = mat(3, 5);  // 5 6
            9'h03D: entry_d = mat(3, 6);  9'h03E: entry_d = mat(3, 7);  // 7 8
            9'h046: entry_d = mat(4, 0);  9'h045: entry_d = mat(4, 1);  // 9 0
            9'h04E: entry_d = mat(4, 2);  9'h055: entry_d = mat(4, 3);  // - =
            9'h044: entry_d = mat(4, 4);  9'h04D: entry_d = mat(4, 5);  // O P
            9'h054: entry_d = mat(4, 6);  9'h05B: entry_d = mat(4, 7);  // [ ]
            9'h04C: entry_d = mat(5, 0);  9'h052: entry_d = mat(5, 1);  // ; '
            9'h041: entry_d = mat(5, 2);  9'h049: entry_d = mat(5, 3);  // , .
            9'h04A: entry_d = mat(5, 4);  9'h05D: entry_d = mat(5, 5);  // / backslash
            9'h00E: entry_d = mat(5, 6);  9'h029: entry_d = mat(5, 7);  // ` SPACE
            9'h076: entry_d = mat(6, 0);  9'h00D: entry_d = mat(6, 1);  // ESC TAB
            9'h066: entry_d = mat(6, 2);  9'h005: entry_d = mat(6, 3);  // BKSP F1
            9'h006: entry_d = mat(6, 4);  9'h004: entry_d = mat(6, 5);  // F2 F3
            9'h058: entry_d = mat(6, 6);  9'h05A: entry_d = mat(6, 7);  // CAPS RETURN
            9'h16B: entry_d = mat(7, 0);  9'h174: entry_d = mat(7, 1);  // LEFT RIGHT
            9'h175: entry_d = mat(7, 2);  9'h172: entry_d = mat(7, 3);  // UP DOWN
            9'h170: entry_d = mat(7, 4);  9'h171: entry_d = mat(7, 5);  // INS DEL
            9'h16C: entry_d = mat(7, 6);  9'h00C: entry_d = mat(7, 7);  // HOME F4
            9'h012: entry_d.kind = KindShiftL;
            9'h059: entry_d.kind = KindShiftR;
            9'h014: entry_d.kind = KindCtrl;
            9'h114: entry_d.kind = KindCtrl;   // right CTRL
            9'h011: entry_d.kind = KindGraph;
            default: entry_d = EntryNone;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        entry_o <= entry_d;
    end

endmodule

// File: rtl/einstein_keyboard.sv
// PS/2 key events to Tatung Einstein 8x8 keyboard matrix, modifiers and key-down strobe.
//   clk_sys, reset : system clock, synchronous active-high reset
//   ps2_key        : [10] toggle per event, [9] make, [8] E0, [7:0] scancode
//   release_all    : one-cycle pulse dropping every held key and modifier
//   kb_row         : active-low row select (from PSG port A)
//   kb_col         : active-low column data (to PSG port B), combinational from kb_row
//   kb_shift/ctrl/graph : active-low modifier lines
//   kb_down        : high while a matrix key is held, low gap on each new press
module einstein_keyboard
    import einstein_kbd_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        release_all,
    input  logic [7:0]  kb_row,
    output logic [7:0]  kb_col,
    output logic        kb_shift,
    output logic        kb_ctrl,
    output logic        kb_graph,
    output logic        kb_down
);

    localparam int unsigned   GapW    = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES);

    // S0: event capture
    logic       prev_tog_q, prev_tog_d;
    logic       s0_valid_q, s0_valid_d;
    logic [9:0] s0_key_q, s0_key_d;  // {make, ext, code}
    // S1: lookup result (entry registered inside the map)
    logic       s1_valid_q, s1_valid_d;
    logic       s1_make_q, s1_make_d;
    map_entry_t s1_entry;
    // S2: keyboard state
    logic [7:0][7:0] key_mat_q, key_mat_d;
    logic            shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic            ctrl_q, ctrl_d, graph_q, graph_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            kb_down_q, kb_down_d;

    einstein_kbd_map u_map (
        .clk_sys (clk_sys),
        .key_i   (s0_key_q[8:0]),
        .entry_o (s1_entry)
    );

    always_comb begin
        prev_tog_d = ps2_key[10];
        s0_valid_d = ps2_key[10] != prev_tog_q;
        s0_key_d   = ps2_key[9:0];
        s1_valid_d = s0_valid_q;
        s1_make_d  = s0_key_q[9];
    end

    always_comb begin
        key_mat_d = key_mat_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        ctrl_d    = ctrl_q;
        graph_d   = graph_q;
        gap_cnt_d = (gap_cnt_q != '0) ? gap_cnt_q - GapW'(1) : '0;
        if (release_all) begin
            key_mat_d = '0;
            shift_l_d = 1'b0;
            shift_r_d = 1'b0;
            ctrl_d    = 1'b0;
            graph_d   = 1'b0;
            gap_cnt_d = '0;
        end else if (s1_valid_q) begin
            unique case (s1_entry.kind)
                KindMatrix: begin
                    // Only a fresh press restarts the gap; typematic repeats do not.
                    if (s1_make_q && !key_mat_q[s1_entry.row][s1_entry.col]) begin
                        gap_cnt_d = GapLoad;
                    end
                    key_mat_d[s1_entry.row][s1_entry.col] = s1_make_q;
                end
                KindShiftL: shift_l_d = s1_make_q;
                KindShiftR: shift_r_d = s1_make_q;
                KindCtrl:   ctrl_d    = s1_make_q;
                KindGraph:  graph_d   = s1_make_q;
                default: ;
            endcase
        end
        kb_down_d = (|key_mat_d) && (gap_cnt_d == '0);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prev_tog_q <= ps2_key[10];  // no spurious event straight after reset
            s0_valid_q <= 1'b0;
            s0_key_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_make_q  <= 1'b0;
            key_mat_q  <= '0;
            shift_l_q  <= 1'b0;
            shift_r_q  <= 1'b0;
            ctrl_q     <= 1'b0;
            graph_q    <= 1'b0;
            gap_cnt_q  <= '0;
            kb_down_q  <= 1'b0;
        end else begin
            prev_tog_q <= prev_tog_d;
            s0_valid_q <= s0_valid_d;
            s0_key_q   <= s0_key_d;
            s1_valid_q <= s1_valid_d;
            s1_make_q  <= s1_make_d;
            key_mat_q  <= key_mat_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            ctrl_q     <= ctrl_d;
            graph_q    <= graph_d;
            gap_cnt_q  <= gap_cnt_d;
            kb_down_q  <= kb_down_d;
        end
    end

    // A column reads low if any selected (low) row has a pressed key in it.
    always_comb begin
        kb_col = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            if (!kb_row[r]) begin
                kb_col = kb_col & ~key_mat_q[r];
            end
        end
    end

    assign kb_shift = ~(shift_l_q | shift_r_q);
    assign kb_ctrl  = ~ctrl_q;
    assign kb_graph = ~graph_q;
    assign kb_down  = kb_down_q;

endmodule

// File: tb/tb_einstein_keyboard.sv
// Directed bench for einstein_keyboard: stimulus pushes expected output values into a
// scoreboard queue; a monitor on the falling clock edge pops and compares them.
module tb_einstein_keyboard;
    import einstein_kbd_pkg::*;

    localparam int SigCol   = 0;
    localparam int SigShift = 1;
    localparam int SigCtrl  = 2;
    localparam int SigGraph = 3;
    localparam int SigDown  = 4;

    typedef struct {
        string      name;
        int         sig;
        logic [7:0] exp;
    } chk_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        release_all;
    logic [7:0]  kb_row;
    logic [7:0]  kb_col;
    logic        kb_shift, kb_ctrl, kb_graph, kb_down;

    chk_t       sb[$];
    chk_t       mon_e;
    logic [7:0] act;
    int         total = 0;
    int         bad   = 0;

    einstein_keyboard dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .release_all (release_all),
        .kb_row      (kb_row),
        .kb_col      (kb_col),
        .kb_shift    (kb_shift),
        .kb_ctrl     (kb_ctrl),
        .kb_graph    (kb_graph),
        .kb_down     (kb_down)
    );

    always #5 clk_sys = ~clk_sys;

    // Monitor: compare every queued expectation against the outputs of this cycle.
    always @(negedge clk_sys) begin
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            case (mon_e.sig)
                SigCol:   act = kb_col;
                SigShift: act = {7'd0, kb_shift};
                SigCtrl:  act = {7'd0, kb_ctrl};
                SigGraph: act = {7'd0, kb_graph};
                default:  act = {7'd0, kb_down};
            endcase
            total++;
            if (act !== mon_e.exp) begin
                bad++;
                $display("FAIL %s: got %02h want %02h", mon_e.name, act, mon_e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic expect_sig(input string name, input int sig, input logic [7:0] exp);
        chk_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Immediate check of a registered output, just after the sampling edge.
    task automatic check_now(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, got, exp);
        end
    endtask

    // Toggle a new event in; returns just after the edge that samples it.
    task automatic send(input logic make, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], make, ext, code};
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        ps2_key     = '0;
        release_all = 1'b0;
        kb_row      = 8'hFF;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        kb_row = 8'hFE;
        check_now("rst_down_now", kb_down, 1'b0);
        expect_sig("rst_col", SigCol, 8'hFF);
        expect_sig("rst_shift", SigShift, 8'h01);
        expect_sig("rst_ctrl", SigCtrl, 8'h01);
        expect_sig("rst_graph", SigGraph, 8'h01);
        expect_sig("rst_down", SigDown, 8'h00);
        tick();

        // First press: A; down rises 4 cycles after the apply edge
        send(1'b1, 1'b0, ScA);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                kb_row = 8'hFD;
                expect_sig("a_col_row1", SigCol, 8'hFE);
            end else if (i == 1) begin
                kb_row = 8'hFE;
                expect_sig("a_col_row0", SigCol, 8'hFF);
            end
            expect_sig("a_gap", SigDown, 8'h00);
            tick();
        end
        check_now("a_down_rise_now", kb_down, 1'b1);
        expect_sig("a_down_rise", SigDown, 8'h01);
        tick();

        // Typematic repeats back to back: no gap
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, ScA);
        for (int i = 0; i < 6; i++) begin
            expect_sig("repeat_no_gap", SigDown, 8'h01);
            tick();
        end

        // New press Q while A held: 4-cycle gap then high again
        send(1'b1, 1'b0, ScQ);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_sig("q_gap", SigDown, 8'h00);
            tick();
        end
        check_now("q_down_rise_now", kb_down, 1'b1);
        expect_sig("q_down_rise", SigDown, 8'h01);
        kb_row = 8'hFC;
        expect_sig("q_a_col", SigCol, 8'hFE);
        tick();

        // Shifts tracked separately
        send(1'b1, 1'b0, ScShiftL);
        send(1'b1, 1'b0, ScShiftR);
        send(1'b0, 1'b0, ScShiftL);
        tick();
        tick();
        expect_sig("shift_other_held", SigShift, 8'h00);
        tick();
        send(1'b0, 1'b0, ScShiftR);
        expect_sig("shift_pending0", SigShift, 8'h00);
        tick();
        expect_sig("shift_pending1", SigShift, 8'h00);
        tick();
        expect_sig("shift_released", SigShift, 8'h01);
        tick();

        // GRAPH
        send(1'b1, 1'b0, ScGraph);
        tick();
        tick();
        expect_sig("graph_held", SigGraph, 8'h00);
        send(1'b0, 1'b0, ScGraph);
        tick();
        tick();
        expect_sig("graph_released", SigGraph, 8'h01);
        tick();

        // Extended UP, plain 75 must not alias it, unmapped 7E does nothing
        send(1'b1, 1'b1, ScUp);
        tick();
        tick();
        kb_row = 8'h7F;
        expect_sig("up_col", SigCol, 8'hFB);
        send(1'b0, 1'b0, ScUp);
        tick();
        tick();
        expect_sig("plain75_no_alias", SigCol, 8'hFB);
        send(1'b1, 1'b0, 8'h7E);
        tick();
        tick();
        kb_row = 8'h00;
        expect_sig("unmapped_col", SigCol, 8'hFA);
        expect_sig("unmapped_no_gap", SigDown, 8'h01);
        expect_sig("unmapped_shift", SigShift, 8'h01);
        tick();

        // CTRL held, then release_all collides with the apply of a RETURN make
        send(1'b1, 1'b0, ScCtrl);
        tick();
        tick();
        expect_sig("ctrl_held", SigCtrl, 8'h00);
        send(1'b1, 1'b0, ScReturn);
        tick();
        release_all = 1'b1;
        tick();
        release_all = 1'b0;
        expect_sig("rel_col", SigCol, 8'hFF);
        expect_sig("rel_ctrl", SigCtrl, 8'h01);
        expect_sig("rel_down", SigDown, 8'h00);
        tick();
        repeat (5) tick();
        expect_sig("rel_no_late_down", SigDown, 8'h00);
        expect_sig("rel_col_late", SigCol, 8'hFF);
        tick();

        // All rows idle
        kb_row = 8'hFF;
        expect_sig("idle_rows", SigCol, 8'hFF);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
